// File: rtl/case_3_acc_pkg.sv
// Shared constants and FSM state type for the product accumulator.
package case_3_acc_pkg;

   localparam int DIN_WIDTH = 12;
   localparam int ACC_WIDTH = 16;
   localparam int MAX_LEN   = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/case_3_sat_add.sv
// Signed two's-complement adder with clamping to the representable range.
module case_3_sat_add #(
   parameter int ACC_WIDTH = case_3_acc_pkg::ACC_WIDTH
) (
   input  logic [ACC_WIDTH-1:0] i_acc,
   input  logic [ACC_WIDTH-1:0] i_addend,
   output logic [ACC_WIDTH-1:0] o_sum,
   output logic                 o_sat_flag
);

   logic [ACC_WIDTH:0] w_wide;

   assign w_wide = {i_acc[ACC_WIDTH-1], i_acc} + {i_addend[ACC_WIDTH-1], i_addend};

   // Overflow shows up as disagreement between the guard bit and the result sign.
   always_comb begin
      o_sat_flag = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
      o_sum      = w_wide[ACC_WIDTH-1:0];
      if (o_sat_flag) begin
         o_sum = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/case_3_prod_acc.sv
// Frame accumulator: sums signed product beats with saturation and presents
// one registered result per frame through a valid/ready handshake.
module case_3_prod_acc #(
   parameter int DIN_WIDTH = case_3_acc_pkg::DIN_WIDTH,
   parameter int ACC_WIDTH = case_3_acc_pkg::ACC_WIDTH,
   parameter int MAX_LEN   = case_3_acc_pkg::MAX_LEN
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic [DIN_WIDTH-1:0]      prod_din,
   input  logic                      prod_valid,
   input  logic                      prod_last,
   output logic                      prod_ready,
   output logic [ACC_WIDTH-1:0]      acc_dout,
   output logic [$clog2(MAX_LEN):0]  acc_cnt,
   output logic                      acc_sat,
   output logic                      acc_valid,
   input  logic                      acc_ready
);

   import case_3_acc_pkg::*;

   localparam int               CNT_W  = $clog2(MAX_LEN) + 1;
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LEN);

   acc_state_t r_state, w_state_nxt;

   logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt, w_din_ext, w_sum;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                 r_sat, w_sat_nxt, w_sat_flag;
   logic                 w_accept, w_frame_end;

   logic [ACC_WIDTH-1:0] r_dout;
   logic [CNT_W-1:0]     r_dcnt;
   logic                 r_dsat;

   assign w_din_ext  = ACC_WIDTH'($signed(prod_din));
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

   // Decoded from state only, so acc_ready never reaches prod_ready.
   assign prod_ready = (r_state != OUT) && !ap_rst;
   assign w_accept   = prod_valid && prod_ready;

   assign acc_valid  = (r_state == OUT);
   assign acc_dout   = r_dout;
   assign acc_cnt    = r_dcnt;
   assign acc_sat    = r_dsat;

   case_3_sat_add #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_sat_add (
      .i_acc      (r_acc),
      .i_addend   (w_din_ext),
      .o_sum      (w_sum),
      .o_sat_flag (w_sat_flag)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_sat_nxt   = r_sat;
      w_frame_end = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_acc_nxt   = w_din_ext;
               w_cnt_nxt   = CNT_W'(1);
               w_sat_nxt   = 1'b0;
               w_frame_end = prod_last || (LP_MAX == CNT_W'(1));
               w_state_nxt = w_frame_end ? OUT : ACC;
            end
         end
         ACC: begin
            if (w_accept) begin
               w_acc_nxt   = w_sum;
               w_cnt_nxt   = w_cnt_inc;
               w_sat_nxt   = r_sat | w_sat_flag;
               w_frame_end = prod_last || (w_cnt_inc == LP_MAX);
               w_state_nxt = w_frame_end ? OUT : ACC;
            end
         end
         OUT: begin
            if (acc_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_sat  <= 1'b0;
         r_dout <= '0;
         r_dcnt <= '0;
         r_dsat <= 1'b0;
      end else begin
         r_acc <= w_acc_nxt;
         r_cnt <= w_cnt_nxt;
         r_sat <= w_sat_nxt;
         if (w_frame_end) begin
            r_dout <= w_acc_nxt;
            r_dcnt <= w_cnt_nxt;
            r_dsat <= w_sat_nxt;
         end
      end
   end

endmodule

// File: tb/tb_case_3_prod_acc.sv
// Self-checking bench for case_3_prod_acc: directed frames plus randomized
// traffic scored against a queue-based arithmetic reference model.
`timescale 1ns/1ps
module tb_case_3_prod_acc;

   localparam int DW   = 12;
   localparam int AW   = 16;
   localparam int ML   = 64;
   localparam int CW   = $clog2(ML) + 1;
   localparam int AMAX = (1 << (AW-1)) - 1;
   localparam int AMIN = -(1 << (AW-1));

   typedef struct {
      int dout;
      int cnt;
      int sat;
   } res_t;

   logic                 ap_clk = 1'b0;
   logic                 ap_rst;
   logic signed [DW-1:0] prod_din;
   logic                 prod_valid;
   logic                 prod_last;
   logic                 prod_ready;
   logic signed [AW-1:0] acc_dout;
   logic [CW-1:0]        acc_cnt;
   logic                 acc_sat;
   logic                 acc_valid;
   logic                 acc_ready;

   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_results = 0;
   int   cur[$];
   res_t expq[$];
   bit   pend_lat = 1'b0;
   bit   rnd_done = 1'b0;

   case_3_prod_acc #(
      .DIN_WIDTH (DW),
      .ACC_WIDTH (AW),
      .MAX_LEN   (ML)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .prod_din   (prod_din),
      .prod_valid (prod_valid),
      .prod_last  (prod_last),
      .prod_ready (prod_ready),
      .acc_dout   (acc_dout),
      .acc_cnt    (acc_cnt),
      .acc_sat    (acc_sat),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Frame sum clamped after every addition; sat records any clamp.
   function automatic res_t model(input int q[$]);
      res_t r;
      int   s;
      s     = 0;
      r.sat = 0;
      foreach (q[i]) begin
         s = s + q[i];
         if (s > AMAX) begin
            s = AMAX;
            r.sat = 1;
         end else if (s < AMIN) begin
            s = AMIN;
            r.sat = 1;
         end
      end
      r.dout = s;
      r.cnt  = q.size();
      return r;
   endfunction

   always @(negedge ap_clk) begin
      res_t e;
      if (ap_rst) begin
         cur.delete();
         expq.delete();
         pend_lat = 1'b0;
      end else begin
         if (pend_lat) begin
            chk("latency_valid", acc_valid, 1);
            pend_lat = 1'b0;
         end
         if (acc_valid) begin
            chk("out_pready_low", prod_ready, 0);
            if (expq.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = expq[0];
               chk("sb_dout", acc_dout, e.dout);
               chk("sb_cnt", acc_cnt, e.cnt);
               chk("sb_sat", acc_sat, e.sat);
            end
            if (acc_ready) begin
               n_results++;
               if (expq.size() != 0) void'(expq.pop_front());
            end
         end
         if (prod_valid && prod_ready) begin
            cur.push_back(int'(prod_din));
            if (prod_last || cur.size() == ML) begin
               expq.push_back(model(cur));
               cur.delete();
               pend_lat = 1'b1;
            end
         end
      end
   end

   task automatic send(input int d, input bit l);
      int n;
      n          = 0;
      prod_din   = d[DW-1:0];
      prod_valid = 1'b1;
      prod_last  = l;
      @(negedge ap_clk);
      while (!prod_ready && n < 200) begin
         n++;
         @(negedge ap_clk);
      end
      if (!prod_ready) chk("send_timeout", 0, 1);
      @(posedge ap_clk);
      #1;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   task automatic get_result(output int d, output int c, output int s,
                             output int pr, output int w);
      w = 0;
      @(negedge ap_clk);
      while (!acc_valid && w < 200) begin
         w++;
         @(negedge ap_clk);
      end
      if (!acc_valid) chk("result_timeout", 0, 1);
      d  = int'(acc_dout);
      c  = int'(acc_cnt);
      s  = int'(acc_sat);
      pr = int'(prod_ready);
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
      int d, c, s, pr, w, nr, len, v, big;
      ap_rst     = 1'b1;
      prod_din   = '0;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      acc_ready  = 1'b0;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_valid", acc_valid, 0);
      chk("rst_dout", acc_dout, 0);
      chk("rst_cnt", acc_cnt, 0);
      chk("rst_sat", acc_sat, 0);
      chk("rst_pready", prod_ready, 0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("post_rst_pready", prod_ready, 1);
      @(posedge ap_clk); #1;

      acc_ready = 1'b1;
      send(5, 0); send(-3, 0); send(100, 1);
      get_result(d, c, s, pr, w);
      chk("basic_lat", w, 0);
      chk("basic_dout", d, 102);
      chk("basic_cnt", c, 3);
      chk("basic_sat", s, 0);

      for (int i = 0; i < 20; i++) send(2047, i == 19);
      get_result(d, c, s, pr, w);
      chk("satpos_dout", d, 32767);
      chk("satpos_cnt", c, 20);
      chk("satpos_sat", s, 1);
      for (int i = 0; i < 20; i++) send(-2048, i == 19);
      get_result(d, c, s, pr, w);
      chk("satneg_dout", d, -32768);
      chk("satneg_sat", s, 1);

      for (int i = 0; i < 64; i++) send(1, 0);
      get_result(d, c, s, pr, w);
      chk("maxlen_lat", w, 0);
      chk("maxlen_pready", pr, 0);
      chk("maxlen_dout", d, 64);
      chk("maxlen_cnt", c, 64);

      acc_ready = 1'b0;
      send(-7, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         chk("stall_valid", acc_valid, 1);
         chk("stall_dout", acc_dout, -7);
         chk("stall_pready", prod_ready, 0);
         @(posedge ap_clk); #1;
         prod_valid = (i == 1);
         prod_last  = (i == 1);
         prod_din   = 12'sd33;
      end
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      acc_ready  = 1'b1;
      get_result(d, c, s, pr, w);
      chk("stall_rel_dout", d, -7);
      chk("stall_rel_cnt", c, 1);
      @(negedge ap_clk);
      chk("post_hs_valid", acc_valid, 0);
      chk("post_hs_pready", prod_ready, 1);
      @(posedge ap_clk); #1;

      nr = n_results;
      send(3, 0); send(9, 0);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      chk("midrst_pready", prod_ready, 0);
      chk("midrst_valid", acc_valid, 0);
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("midrst_rel_pready", prod_ready, 1);
      chk("midrst_rel_cnt", acc_cnt, 0);
      @(posedge ap_clk); #1;
      send(4, 0); send(4, 1);
      get_result(d, c, s, pr, w);
      chk("midrst_dout", d, 8);
      chk("midrst_cnt", c, 2);
      chk("midrst_nres", n_results - nr, 1);

      send(1, 1);
      get_result(d, c, s, pr, w);
      chk("b2b1_dout", d, 1);
      chk("b2b1_cnt", c, 1);
      repeat (3) @(posedge ap_clk);
      #1;
      send(2, 1);
      get_result(d, c, s, pr, w);
      chk("b2b2_dout", d, 2);
      chk("b2b2_cnt", c, 1);
      send(3, 0);
      repeat (2) @(posedge ap_clk);
      #1;
      send(4, 1);
      get_result(d, c, s, pr, w);
      chk("bubble_dout", d, 7);
      chk("bubble_cnt", c, 2);

      fork
         begin
            for (int f = 0; f < 40; f++) begin
               len = $urandom_range(1, 80);
               big = $urandom_range(0, 1);
               for (int b = 0; b < len; b++) begin
                  if (big != 0) v = int'($urandom_range(0, 4095)) - 2048;
                  else          v = int'($urandom_range(0, 40)) - 20;
                  send(v, b == len - 1);
                  if ($urandom_range(0, 3) == 0) begin
                     repeat ($urandom_range(1, 2)) @(posedge ap_clk);
                     #1;
                  end
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge ap_clk); #1;
               acc_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      acc_ready = 1'b1;
      w = 0;
      while (expq.size() != 0 && w < 300) begin
         @(posedge ap_clk);
         w++;
      end
      #1;
      chk("drain_pending", expq.size(), 0);
      chk("drain_partial", cur.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/case_3_prod_acc.md
CASE_3_PROD_ACC -- requirements
Module: case_3_prod_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 12: width of the signed product input.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: width of the signed accumulator and result (ACC_WIDTH >= DIN_WIDTH).
REQ-003 SHALL have parameter MAX_LEN, default 64: maximum beats per frame before a forced frame end.
REQ-004 SHALL have port ap_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port prod_din, input, DIN_WIDTH: signed product from the upstream multiplier stage.
REQ-007 SHALL have port prod_valid, input, 1: prod_din valid.
REQ-008 SHALL have port prod_last, input, 1: current beat ends the frame.
REQ-009 SHALL have port prod_ready, output, 1: block accepts a beat.
REQ-010 SHALL have port acc_dout, output, ACC_WIDTH: signed frame sum.
REQ-011 SHALL have port acc_cnt, output, clog2(MAX_LEN)+1: beats in the frame.
REQ-012 SHALL have port acc_sat, output, 1: saturation occurred during the frame.
REQ-013 SHALL have port acc_valid, output, 1: result valid.
REQ-014 SHALL have port acc_ready, input, 1: downstream accepts the result.

Function
REQ-015 SHALL implement an FSM with states IDLE (no beats yet), ACC (frame open) and OUT (result presented).
REQ-016 SHALL drive prod_ready=1 in IDLE and ACC and prod_ready=0 in OUT, as a registered or state-decoded signal with no combinational path from acc_ready.
REQ-017 SHALL accept a beat only on a cycle with prod_valid=1 and prod_ready=1.
REQ-018 SHALL load the accumulator with sext(prod_din) on an accepted beat in IDLE, set count=1 and acc_sat=0, and move to ACC; no stale sum carries across frames.
REQ-019 SHALL, on an accepted beat in ACC, set acc = sat(acc + sext(prod_din)) and count = count+1.
REQ-020 SHALL clamp the sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] when saturating, set acc_sat whenever clamping occurs, and hold acc_sat sticky until the frame is consumed.
REQ-021 SHALL end the frame on an accepted beat that has prod_last=1 or that makes count=MAX_LEN, covering both IDLE and ACC.
REQ-022 SHALL enter OUT on the cycle after the frame-ending beat, with acc_valid=1 and acc_dout, acc_cnt and acc_sat registered; latency is 1 cycle.
REQ-023 SHALL keep acc_valid, acc_dout, acc_cnt and acc_sat stable in OUT while acc_ready=0.
REQ-024 SHALL, on acc_valid=1 and acc_ready=1, drop acc_valid on the next cycle and return to IDLE; the next beat is accepted one cycle after the handshake.
REQ-025 SHALL leave state unchanged in IDLE or ACC when prod_valid=0; bubbles are allowed mid-frame.
REQ-026 SHALL ignore prod_last when prod_valid=0.

Reset
REQ-027 SHALL, while ap_rst=1, force state IDLE and set acc, count, acc_sat and acc_valid to 0 and acc_dout and acc_cnt to 0.
REQ-028 SHALL drive prod_ready=0 during reset and prod_ready=1 in the first cycle after reset.
REQ-029 SHALL discard any partial frame or undelivered result on reset mid-operation without emitting it.

Structure
REQ-030 SHALL place in a shared package case_3_acc_pkg: the FSM state enum and the default-width constants DIN_WIDTH, ACC_WIDTH and MAX_LEN.
REQ-031 SHALL place the saturating add in one combinational sub-module case_3_sat_add, with inputs acc and sext(din) and outputs sum and sat_flag; all registers stay in the top module.

Verification
REQ-032 SHALL verify: beats 5, -3, 100 (last on 100), acc_ready=1 -> acc_valid one cycle after beat 3 with acc_dout=102, acc_cnt=3, acc_sat=0.
REQ-033 SHALL verify: 20 beats of 2047, last on beat 20 -> acc_dout=32767, acc_sat=1, acc_cnt=20; repeat with -2048 -> acc_dout=-32768, acc_sat=1.
REQ-034 SHALL verify: 64 beats of 1 with prod_last=0 -> forced frame end, acc_dout=64, acc_cnt=64, and prod_ready=0 the following cycle.
REQ-035 SHALL verify: single beat -7 with last=1 and acc_ready held 0 for 5 cycles -> outputs stable, prod_ready=0, a prod_valid pulse ignored, then acc_dout=-7 released on the handshake.
REQ-036 SHALL verify: ap_rst asserted after 2 beats of a frame, then frame 4, 4 (last) -> acc_dout=8, acc_cnt=2, with no earlier result emitted.
REQ-037 SHALL verify: back-to-back frames {1 last}, {2 last} with acc_ready=1 and idle cycles inserted mid-frame -> results 1 then 2, each with acc_cnt=1.
